// File: rtl/msp430_pkg.sv
// Shared constants for the memory-address-bus sequencer: FSM state
// encoding, MAB_SEL source codes, instruction format codes, and a helper
// that identifies the states performing a memory access.
package msp430_pkg;

    localparam logic [3:0] ST_IDLE    = 4'd0;
    localparam logic [3:0] ST_FETCH   = 4'd1;
    localparam logic [3:0] ST_DECODE  = 4'd2;
    localparam logic [3:0] ST_SRC_EXT = 4'd3;
    localparam logic [3:0] ST_SRC_RD  = 4'd4;
    localparam logic [3:0] ST_DST_EXT = 4'd5;
    localparam logic [3:0] ST_DST_RD  = 4'd6;
    localparam logic [3:0] ST_EXEC    = 4'd7;
    localparam logic [3:0] ST_DST_WR  = 4'd8;
    localparam logic [3:0] ST_PUSH    = 4'd9;
    localparam logic [3:0] ST_FIN     = 4'd10;

    localparam logic [2:0] MAB_PC   = 3'd0;
    localparam logic [2:0] MAB_DOUT = 3'd1;
    localparam logic [2:0] MAB_SOUT = 3'd2;
    localparam logic [2:0] MAB_CALC = 3'd3;
    localparam logic [2:0] MAB_SP   = 3'd4;

    localparam logic [1:0] FMT_DOUBLE   = 2'b00;
    localparam logic [1:0] FMT_SINGLE   = 2'b01;
    localparam logic [1:0] FMT_JUMP     = 2'b10;
    localparam logic [1:0] FMT_JUMP_ALT = 2'b11;

    // True for states that wait on the memory ready handshake.
    function automatic logic is_access_state(input logic [3:0] st);
        case (st)
            ST_FETCH, ST_SRC_EXT, ST_SRC_RD, ST_DST_EXT,
            ST_DST_RD, ST_DST_WR, ST_PUSH: return 1'b1;
            default:                       return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mab_sequencer_am_decode.sv
// Addressing-mode decoder: chooses the successor states of DECODE,
// SRC_EXT, SRC_RD (destination step) and EXEC from the instruction
// format and addressing-mode fields. Purely combinational.
module am_decode
    import msp430_pkg::*;
(
    input  logic [1:0] fmt_i,
    input  logic [1:0] as_i,
    input  logic       ad_i,
    input  logic       src_is_pc_i,
    input  logic       is_push_i,
    output logic [3:0] decode_nxt_o,
    output logic [3:0] src_ext_nxt_o,
    output logic [3:0] dst_step_o,
    output logic [3:0] exec_nxt_o
);

    logic is_jump_s;
    logic dst_mem_s;

    assign is_jump_s = (fmt_i == FMT_JUMP) || (fmt_i == FMT_JUMP_ALT);
    assign dst_mem_s = (fmt_i == FMT_DOUBLE) && ad_i;

    // Successor-state selection for every operand-dependent branch point.
    always_comb begin
        dst_step_o    = ST_EXEC;
        decode_nxt_o  = ST_EXEC;
        src_ext_nxt_o = ST_EXEC;
        exec_nxt_o    = ST_FIN;

        if (dst_mem_s) begin
            dst_step_o = ST_DST_EXT;
        end else begin
            dst_step_o = ST_EXEC;
        end

        if (is_jump_s) begin
            decode_nxt_o = ST_EXEC;
        end else if ((as_i == 2'b01) || ((as_i == 2'b11) && src_is_pc_i)) begin
            decode_nxt_o = ST_SRC_EXT;
        end else if (as_i[1]) begin
            decode_nxt_o = ST_SRC_RD;
        end else begin
            decode_nxt_o = dst_step_o;
        end

        // Indexed source still needs its operand read; immediate is done.
        if (as_i == 2'b01) begin
            src_ext_nxt_o = ST_SRC_RD;
        end else begin
            src_ext_nxt_o = dst_step_o;
        end

        if (dst_mem_s) begin
            exec_nxt_o = ST_DST_WR;
        end else if ((fmt_i == FMT_SINGLE) && is_push_i) begin
            exec_nxt_o = ST_PUSH;
        end else begin
            exec_nxt_o = ST_FIN;
        end
    end

endmodule

// File: rtl/mab_sequencer.sv
// Memory-address-bus sequencer for one instruction: fetch, operand
// extension words, operand reads, execute, write-back/push, done.
// Optional macro MAB_WAITSTATE_EN: when defined, access states wait for
// MEM_RDY; otherwise every access completes in one cycle.
module mab_sequencer
    import msp430_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       START,
    input  logic [1:0] FMT,
    input  logic [1:0] As,
    input  logic       Ad,
    input  logic       SRC_IS_PC,
    input  logic       IS_PUSH,
    input  logic       MEM_RDY,
    output logic [2:0] MAB_SEL,
    output logic       MEM_RD,
    output logic       MEM_WR,
    output logic       PC_INC,
    output logic       IR_LD,
    output logic       EXEC_EN,
    output logic       BUSY,
    output logic       DONE
);

    logic [3:0] state_q, state_d;
    logic [1:0] fmt_q, as_q;
    logic       ad_q, src_pc_q, push_q;
    logic       in_decode_s;
    logic       rdy_s;
    logic [1:0] dec_fmt_s, dec_as_s;
    logic       dec_ad_s, dec_pc_s, dec_push_s;
    logic [3:0] decode_nxt_s, src_ext_nxt_s, dst_step_s, exec_nxt_s;

`ifdef MAB_WAITSTATE_EN
    assign rdy_s = MEM_RDY;
`else
    // Ready is forced high; MEM_RDY is referenced only to keep it connected.
    assign rdy_s = MEM_RDY | 1'b1;
`endif

    // Live operand fields are used while decoding, the captured copy after.
    assign in_decode_s = (state_q == ST_DECODE);
    assign dec_fmt_s   = in_decode_s ? FMT       : fmt_q;
    assign dec_as_s    = in_decode_s ? As        : as_q;
    assign dec_ad_s    = in_decode_s ? Ad        : ad_q;
    assign dec_pc_s    = in_decode_s ? SRC_IS_PC : src_pc_q;
    assign dec_push_s  = in_decode_s ? IS_PUSH   : push_q;

    am_decode u_am_decode (
        .fmt_i         (dec_fmt_s),
        .as_i          (dec_as_s),
        .ad_i          (dec_ad_s),
        .src_is_pc_i   (dec_pc_s),
        .is_push_i     (dec_push_s),
        .decode_nxt_o  (decode_nxt_s),
        .src_ext_nxt_o (src_ext_nxt_s),
        .dst_step_o    (dst_step_s),
        .exec_nxt_o    (exec_nxt_s)
    );

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Capture the decoded operand fields during DECODE for later branches.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fmt_q    <= 2'b00;
            as_q     <= 2'b00;
            ad_q     <= 1'b0;
            src_pc_q <= 1'b0;
            push_q   <= 1'b0;
        end else if (in_decode_s) begin
            fmt_q    <= FMT;
            as_q     <= As;
            ad_q     <= Ad;
            src_pc_q <= SRC_IS_PC;
            push_q   <= IS_PUSH;
        end else begin
            fmt_q    <= fmt_q;
            as_q     <= as_q;
            ad_q     <= ad_q;
            src_pc_q <= src_pc_q;
            push_q   <= push_q;
        end
    end

    // Next-state logic; access states hold until ready.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    state_d = START ? ST_FETCH : ST_IDLE;
            ST_FETCH:   state_d = rdy_s ? ST_DECODE : ST_FETCH;
            ST_DECODE:  state_d = decode_nxt_s;
            ST_SRC_EXT: state_d = rdy_s ? src_ext_nxt_s : ST_SRC_EXT;
            ST_SRC_RD:  state_d = rdy_s ? dst_step_s : ST_SRC_RD;
            ST_DST_EXT: state_d = rdy_s ? ST_DST_RD : ST_DST_EXT;
            ST_DST_RD:  state_d = rdy_s ? ST_EXEC : ST_DST_RD;
            ST_EXEC:    state_d = exec_nxt_s;
            ST_DST_WR:  state_d = rdy_s ? ST_FIN : ST_DST_WR;
            ST_PUSH:    state_d = rdy_s ? ST_FIN : ST_PUSH;
            ST_FIN:     state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Output decode from the registered state; only the PC_INC/IR_LD
    // pulses are qualified by ready so they never fire on a stalled access.
    always_comb begin
        MAB_SEL = MAB_PC;
        MEM_RD  = 1'b0;
        MEM_WR  = 1'b0;
        PC_INC  = 1'b0;
        IR_LD   = 1'b0;
        EXEC_EN = 1'b0;
        DONE    = 1'b0;
        BUSY    = (state_q != ST_IDLE);
        case (state_q)
            ST_FETCH: begin
                MEM_RD = 1'b1;
                PC_INC = rdy_s;
                IR_LD  = rdy_s;
            end
            ST_SRC_EXT, ST_DST_EXT: begin
                MEM_RD = 1'b1;
                PC_INC = rdy_s;
            end
            ST_SRC_RD: begin
                MEM_RD  = 1'b1;
                MAB_SEL = (as_q == 2'b01) ? MAB_CALC : MAB_SOUT;
            end
            ST_DST_RD: begin
                MEM_RD  = 1'b1;
                MAB_SEL = MAB_DOUT;
            end
            ST_EXEC:   EXEC_EN = 1'b1;
            ST_DST_WR: begin
                MEM_WR  = 1'b1;
                MAB_SEL = MAB_DOUT;
            end
            ST_PUSH: begin
                MEM_WR  = 1'b1;
                MAB_SEL = MAB_SP;
            end
            ST_FIN:    DONE = 1'b1;
            default: begin
                MAB_SEL = MAB_PC;
                BUSY    = is_access_state(state_q) || (state_q != ST_IDLE);
            end
        endcase
    end

endmodule

// File: tb/tb_mab_sequencer.sv
// Directed bench for mab_sequencer: per-cycle expected output vectors are
// queued when an instruction is launched and compared cycle by cycle.
module tb_mab_sequencer;

    logic       clk = 1'b0;
    logic       rst_n, START, Ad, SRC_IS_PC, IS_PUSH, MEM_RDY;
    logic [1:0] FMT, As;
    logic [2:0] MAB_SEL;
    logic       MEM_RD, MEM_WR, PC_INC, IR_LD, EXEC_EN, BUSY, DONE;

    typedef logic [9:0] vec_t;
    vec_t exp_q[$];
    logic rdy_q[$];
    int   n_asserts = 0;
    int   n_fails   = 0;

    vec_t v_f, v_fw, v_d, v_ext, v_src_c, v_src_s, v_dr, v_e, v_dw, v_p, v_n, v_i;

    mab_sequencer dut (
        .clk(clk), .rst_n(rst_n), .START(START), .FMT(FMT), .As(As), .Ad(Ad),
        .SRC_IS_PC(SRC_IS_PC), .IS_PUSH(IS_PUSH), .MEM_RDY(MEM_RDY),
        .MAB_SEL(MAB_SEL), .MEM_RD(MEM_RD), .MEM_WR(MEM_WR), .PC_INC(PC_INC),
        .IR_LD(IR_LD), .EXEC_EN(EXEC_EN), .BUSY(BUSY), .DONE(DONE)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [2:0] sel, input logic rd, input logic wr,
                                input logic pc, input logic ir, input logic ex,
                                input logic bz, input logic dn);
        return {sel, rd, wr, pc, ir, ex, bz, dn};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag);
        vec_t obs;
        vec_t exp_v;
        exp_v = exp_q.pop_front();
        obs   = {MAB_SEL, MEM_RD, MEM_WR, PC_INC, IR_LD, EXEC_EN, BUSY, DONE};
        n_asserts++;
        assert (obs === exp_v) else begin
            n_fails++;
            $error("FAIL %s: observed sel/rd/wr/pc/ir/ex/busy/done=%b expected %b", tag, obs, exp_v);
        end
    endtask

    // Launch one instruction and compare every queued cycle.
    task automatic run(input string tag, input logic [1:0] fmt, input logic [1:0] as_v,
                       input logic ad, input logic src_pc, input logic push,
                       input logic busy_start);
        int cyc;
        cyc = 0;
        FMT = fmt; As = as_v; Ad = ad; SRC_IS_PC = src_pc; IS_PUSH = push;
        MEM_RDY = 1'b1;
        START = 1'b1;
        tick();
        START = 1'b0;
        while (exp_q.size() > 0) begin
            if (rdy_q.size() > 0) MEM_RDY = rdy_q.pop_front();
            else                  MEM_RDY = 1'b1;
            START = busy_start && (cyc == 1 || cyc == 2);
            #1;
            check(tag);
            tick();
            cyc++;
        end
        START   = 1'b0;
        MEM_RDY = 1'b1;
    endtask

    initial begin
        v_f     = mk(3'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        v_fw    = mk(3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        v_d     = mk(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        v_ext   = mk(3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        v_src_c = mk(3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        v_src_s = mk(3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        v_dr    = mk(3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        v_e     = mk(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        v_dw    = mk(3'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        v_p     = mk(3'd4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        v_n     = mk(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        v_i     = 10'd0;

        rst_n = 1'b0; START = 1'b0; FMT = 2'b00; As = 2'b00; Ad = 1'b0;
        SRC_IS_PC = 1'b0; IS_PUSH = 1'b0; MEM_RDY = 1'b1;
        tick();
        tick();
        exp_q.push_back(v_i);
        #1;
        check("reset_state");
        rst_n = 1'b1;
        tick();

        // Register mode: DONE four cycles after START.
        exp_q.push_back(v_f); exp_q.push_back(v_d); exp_q.push_back(v_e);
        exp_q.push_back(v_n); exp_q.push_back(v_i);
        run("reg_mode", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

        // Indexed source and indexed destination.
        exp_q.push_back(v_f); exp_q.push_back(v_d); exp_q.push_back(v_ext);
        exp_q.push_back(v_src_c); exp_q.push_back(v_ext); exp_q.push_back(v_dr);
        exp_q.push_back(v_e); exp_q.push_back(v_dw); exp_q.push_back(v_n);
        exp_q.push_back(v_i);
        run("indexed", 2'b00, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0);

        // Immediate PUSH: extension word, no source read, stack write.
        exp_q.push_back(v_f); exp_q.push_back(v_d); exp_q.push_back(v_ext);
        exp_q.push_back(v_e); exp_q.push_back(v_p); exp_q.push_back(v_n);
        exp_q.push_back(v_i);
        run("imm_push", 2'b01, 2'b11, 1'b0, 1'b1, 1'b1, 1'b0);

        // Indirect source register (As=10) reads via Sout.
        exp_q.push_back(v_f); exp_q.push_back(v_d); exp_q.push_back(v_src_s);
        exp_q.push_back(v_e); exp_q.push_back(v_n); exp_q.push_back(v_i);
        run("indirect", 2'b00, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0);

        // Autoincrement without PC (As=11) is not immediate.
        exp_q.push_back(v_f); exp_q.push_back(v_d); exp_q.push_back(v_src_s);
        exp_q.push_back(v_e); exp_q.push_back(v_n); exp_q.push_back(v_i);
        run("autoinc", 2'b00, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);

        // Jump (FMT=10) skips operands regardless of As/Ad.
        exp_q.push_back(v_f); exp_q.push_back(v_d); exp_q.push_back(v_e);
        exp_q.push_back(v_n); exp_q.push_back(v_i);
        run("jump10", 2'b10, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0);

        // FMT=11 behaves as jump.
        exp_q.push_back(v_f); exp_q.push_back(v_d); exp_q.push_back(v_e);
        exp_q.push_back(v_n); exp_q.push_back(v_i);
        run("jump11", 2'b11, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0);

        // Single-operand with Ad=1 and no push: no destination access.
        exp_q.push_back(v_f); exp_q.push_back(v_d); exp_q.push_back(v_e);
        exp_q.push_back(v_n); exp_q.push_back(v_i);
        run("single_nopush", 2'b01, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);

        // START while busy is ignored; DONE pulses once.
        exp_q.push_back(v_f); exp_q.push_back(v_d); exp_q.push_back(v_e);
        exp_q.push_back(v_n); exp_q.push_back(v_i); exp_q.push_back(v_i);
        run("start_busy", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);

        // MEM_RDY low for three cycles in FETCH.
        rdy_q.push_back(1'b0); rdy_q.push_back(1'b0); rdy_q.push_back(1'b0);
`ifdef MAB_WAITSTATE_EN
        exp_q.push_back(v_fw); exp_q.push_back(v_fw); exp_q.push_back(v_fw);
`endif
        exp_q.push_back(v_f); exp_q.push_back(v_d); exp_q.push_back(v_e);
        exp_q.push_back(v_n); exp_q.push_back(v_i);
        run("waitstate", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        rdy_q.delete();

        // Reset while in DST_RD, with START in the reset cycle.
        exp_q.push_back(v_f); exp_q.push_back(v_d); exp_q.push_back(v_ext);
        exp_q.push_back(v_src_c); exp_q.push_back(v_ext);
        run("pre_reset", 2'b00, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0);
        exp_q.push_back(v_dr);
        #1;
        check("in_dst_rd");
        rst_n = 1'b0;
        START = 1'b1;
        tick();
        exp_q.push_back(v_i);
        #1;
        check("mid_reset");
        rst_n = 1'b1;
        START = 1'b0;
        tick();
        exp_q.push_back(v_i);
        #1;
        check("start_discarded");

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
